// File: rtl/rv_pkg.sv
// rv_pkg: RV32I datapath width, base opcodes and instruction format encoding shared by the decode slice
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: classifies an RV32I instruction by format and builds its sign-extended immediate.
//   instr in 32; fmt out fmt_e; imm out 32; uses_rs1/uses_rs2/has_rd out 1
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output fmt_e        fmt,
  output logic [31:0] imm,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        has_rd
);
  logic [6:0] opc;
  logic       s;
  assign opc = instr[6:0];
  assign s   = instr[31];
  always_comb begin
    fmt = opc == OP ? FMT_R :
          (opc == OP_IMM || opc == LOAD || opc == JALR) ? FMT_I :
          opc == STORE ? FMT_S :
          opc == BRANCH ? FMT_B :
          (opc == LUI || opc == AUIPC) ? FMT_U :
          opc == JAL ? FMT_J : FMT_X;
    imm = fmt == FMT_I ? {{20{s}}, instr[31:20]} :
          fmt == FMT_S ? {{20{s}}, instr[31:25], instr[11:7]} :
          fmt == FMT_B ? {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0} :
          fmt == FMT_U ? {instr[31:12], 12'd0} :
          fmt == FMT_J ? {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0} : 32'd0;
    uses_rs1 = fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B;
    uses_rs2 = fmt == FMT_R || fmt == FMT_S || fmt == FMT_B;
    has_rd   = fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode/operand fetch with EX/MEM/WB bypass, load-use stall and ID/EX register.
//   fetch side: if_valid/if_ready, if_pc, if_instr; reg_file: rs1/rs2 out, val1/val2 in;
//   bypass sources: ex_*, mem_*, wb_*; flush kills ID and incoming; EX side: id_valid/id_ready, id_* payload
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic            ex_wen,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_val,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_val,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd
);
  fmt_e            fmt;
  logic [31:0]     imm;
  logic            uses_rs1, uses_rs2, has_rd, hazard, advance, ex_fwd;
  logic [XLEN-1:0] op1, op2;
  imm_gen u_imm_gen (
    .instr    (if_instr),
    .fmt      (fmt),
    .imm      (imm),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .has_rd   (has_rd)
  );
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  // a load in EX has no result yet, so it never forwards; hazard logic stalls instead
  assign ex_fwd = ex_wen && !ex_is_load;
  assign op1 = rs1 == 5'd0 ? '0 :
               (ex_fwd && ex_rd == rs1) ? ex_val :
               (mem_wen && mem_rd == rs1) ? mem_val :
               (wb_wen && wb_rd == rs1) ? wb_val : val1;
  assign op2 = rs2 == 5'd0 ? '0 :
               (ex_fwd && ex_rd == rs2) ? ex_val :
               (mem_wen && mem_rd == rs2) ? mem_val :
               (wb_wen && wb_rd == rs2) ? wb_val : val2;
  assign hazard = if_valid && ex_wen && ex_is_load && ex_rd != 5'd0 &&
                  ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
  assign advance  = !id_valid || id_ready;
  assign if_ready = advance && !hazard;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= '0;
      id_rs1_val <= '0;
      id_rs2_val <= '0;
      id_imm     <= '0;
      id_rd      <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (advance) begin
      id_valid <= if_valid && !hazard;
      if (if_valid && !hazard) begin
        id_pc      <= if_pc;
        id_instr   <= if_instr;
        id_rs1_val <= op1;
        id_rs2_val <= op2;
        id_imm     <= imm;
        id_rd      <= has_rd ? if_instr[11:7] : 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector self-checking bench for decode_stage
module tb_decode_stage;
  logic        clock = 0, reset_n = 0;
  logic        if_valid = 0, if_ready;
  logic [31:0] if_pc = 0, if_instr = 0;
  logic [4:0]  rs1, rs2;
  logic [31:0] val1 = 0, val2 = 0;
  logic        ex_wen = 0, ex_is_load = 0, mem_wen = 0, wb_wen = 0;
  logic [4:0]  ex_rd = 0, mem_rd = 0, wb_rd = 0;
  logic [31:0] ex_val = 0, mem_val = 0, wb_val = 0;
  logic        flush = 0, id_valid, id_ready = 1;
  logic [31:0] id_pc, id_instr, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rd;
  int errors = 0, checks = 0;
  decode_stage dut (
    .clock(clock), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .rs1(rs1), .rs2(rs2), .val1(val1), .val2(val2),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_val(ex_val),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_val(mem_val),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_val(wb_val), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_rd(id_rd)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic feed(input logic [31:0] pc, input logic [31:0] ins);
    if_valid = 1;
    if_pc    = pc;
    if_instr = ins;
    tick();
  endtask
  initial begin
    tick();
    tick();
    check("rst_valid", {31'd0, id_valid}, 0);
    check("rst_pc", id_pc, 0);
    check("rst_if_ready", {31'd0, if_ready}, 1);
    reset_n = 1;
    // add x9,x5,x0 with x5 written by EX, MEM and WB at once
    val1 = 32'hAAAA; val2 = 32'hBBBB;
    ex_wen = 1; ex_rd = 5; ex_val = 1;
    mem_wen = 1; mem_rd = 5; mem_val = 2;
    wb_wen = 1; wb_rd = 5; wb_val = 3;
    if_valid = 1; if_pc = 32'h100; if_instr = 32'h000284B3;
    #1;
    check("rs1_addr", {27'd0, rs1}, 5);
    check("rs2_addr", {27'd0, rs2}, 0);
    check("byp_if_ready", {31'd0, if_ready}, 1);
    tick();
    check("byp_valid", {31'd0, id_valid}, 1);
    check("byp_pc", id_pc, 32'h100);
    check("byp_instr", id_instr, 32'h000284B3);
    check("byp_ex", id_rs1_val, 1);
    check("byp_x0", id_rs2_val, 0);
    check("byp_rd", {27'd0, id_rd}, 9);
    ex_wen = 0;
    tick();
    check("byp_mem", id_rs1_val, 2);
    mem_wen = 0;
    tick();
    check("byp_wb", id_rs1_val, 3);
    wb_wen = 0;
    tick();
    check("byp_rf", id_rs1_val, 32'hAAAA);
    // reset while the ID/EX register holds a valid instruction
    reset_n = 0;
    tick();
    check("mrst_valid", {31'd0, id_valid}, 0);
    check("mrst_pc", id_pc, 0);
    check("mrst_instr", id_instr, 0);
    check("mrst_op1", id_rs1_val, 0);
    check("mrst_imm", id_imm, 0);
    check("mrst_rd", {27'd0, id_rd}, 0);
    reset_n = 1; if_valid = 0;
    tick();
    check("idle_valid", {31'd0, id_valid}, 0);
    // lw x7 in EX, add x8,x7,x1 in fetch
    ex_wen = 1; ex_is_load = 1; ex_rd = 7; ex_val = 32'hDEAD;
    mem_wen = 1; mem_rd = 7; mem_val = 32'h7777;
    val1 = 32'h1111; val2 = 32'h2222;
    if_valid = 1; if_pc = 32'h200; if_instr = 32'h00138433;
    #1;
    check("lu_if_ready", {31'd0, if_ready}, 0);
    tick();
    check("lu_bubble", {31'd0, id_valid}, 0);
    ex_wen = 0; ex_is_load = 0;
    #1;
    check("lu_release", {31'd0, if_ready}, 1);
    tick();
    check("lu_valid", {31'd0, id_valid}, 1);
    check("lu_pc", id_pc, 32'h200);
    check("lu_op1_mem", id_rs1_val, 32'h7777);
    check("lu_op2_rf", id_rs2_val, 32'h2222);
    check("lu_rd", {27'd0, id_rd}, 8);
    mem_wen = 0;
    // backpressure: lui x3,0x12345 waits behind the held add
    id_ready = 0;
    if_pc = 32'h300; if_instr = 32'h123451B7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_if_ready", {31'd0, if_ready}, 0);
      tick();
      check("bp_valid", {31'd0, id_valid}, 1);
      check("bp_pc", id_pc, 32'h200);
      check("bp_op1", id_rs1_val, 32'h7777);
    end
    id_ready = 1;
    #1;
    check("bp_accept", {31'd0, if_ready}, 1);
    tick();
    check("lui_pc", id_pc, 32'h300);
    check("lui_imm", id_imm, 32'h12345000);
    check("lui_rd", {27'd0, id_rd}, 3);
    // flush wins over a pending load-use hazard
    ex_wen = 1; ex_is_load = 1; ex_rd = 7;
    if_pc = 32'h400; if_instr = 32'h00138433; flush = 1;
    tick();
    check("flush_valid", {31'd0, id_valid}, 0);
    flush = 0; ex_wen = 0; ex_is_load = 0;
    feed(32'h500, 32'hFE20AE23);
    check("sw_imm", id_imm, 32'hFFFFFFFC);
    check("sw_rd", {27'd0, id_rd}, 0);
    feed(32'h504, 32'hFE208CE3);
    check("beq_imm", id_imm, 32'hFFFFFFF8);
    check("beq_rd", {27'd0, id_rd}, 0);
    feed(32'h508, 32'h001000EF);
    check("jal_imm", id_imm, 32'h00000800);
    check("jal_rd", {27'd0, id_rd}, 1);
    // unknown opcode uses no rs, so a load to its rs1 field causes no stall
    ex_wen = 1; ex_is_load = 1; ex_rd = 31;
    if_pc = 32'h50C; if_instr = 32'hFFFFFFFF;
    #1;
    check("unk_if_ready", {31'd0, if_ready}, 1);
    tick();
    check("unk_valid", {31'd0, id_valid}, 1);
    check("unk_imm", id_imm, 0);
    check("unk_rd", {27'd0, id_rd}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
